// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared opcodes, state type and helpers for the dual-lane issue scheduler
//
// Purpose: common definitions for issue_scheduler and pair_hazard.
//   OP_R, OP_I   : the two opcodes the ALU lanes can execute
//   REG_ZERO     : architectural zero register (writes to it never create hazards)
//   state_e      : scheduler FSM state (S_PAIR, S_SPLIT)
//   is_supported : 1 when an opcode can issue on an ALU lane
package issue_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    S_PAIR  = 1'b0,
    S_SPLIT = 1'b1
  } state_e;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I);
  endfunction

endpackage

// File: rtl/pair_hazard.sv
// rtl/pair_hazard.sv - combinational dependency check between lane A and lane B
//
// Purpose: classify the fetched pair so the scheduler can decide dual or split issue.
// Ports:
//   opA, rdA          : lane A opcode and destination
//   opB, rdB          : lane B opcode and destination
//   rs1B, rs2B        : lane B sources
//   supA, supB        : lane opcode is executable on the ALU
//   raw               : lane B reads the register lane A writes
//   waw               : both lanes write the same register
// raw/waw are only asserted when both lanes are supported and rdA is not x0,
// so the scheduler can use (raw | waw) directly as its split condition.
module pair_hazard
  import issue_pkg::*;
(
  input  logic [6:0] opA,
  input  logic [4:0] rdA,
  input  logic [6:0] opB,
  input  logic [4:0] rdB,
  input  logic [4:0] rs1B,
  input  logic [4:0] rs2B,
  output logic       supA,
  output logic       supB,
  output logic       raw,
  output logic       waw
);

  logic check_en;

  assign supA     = is_supported(opA);
  assign supB     = is_supported(opB);
  // A write to x0 is discarded, so nothing in B can depend on it.
  assign check_en = supA && supB && (rdA != REG_ZERO);

  // rs2 only names a register for R-type; in I-type those bits are immediate.
  assign raw = check_en && ((rs1B == rdA) || ((opB == OP_R) && (rs2B == rdA)));
  assign waw = check_en && (rdB == rdA);

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - dual-lane ALU issue scheduler with split-on-hazard and perf counters
//
// Purpose: decide each cycle which of the two lanes of a fetched pair execute,
// splitting a dependent pair over two cycles (A then B) and honouring a stall.
// Ports:
//   clk, rst               : core clock, asynchronous active-high reset
//   in_valid               : fetched pair present
//   opA/rdA/rs1A/rs2A      : lane A fields
//   opB/rdB/rs1B/rs2B      : lane B fields
//   trigger                : stall request, blocks all issue while high
//   clr_cnt                : synchronous clear of the performance counters
//   issue_a, issue_b       : per-lane execute enables (Mealy)
//   pair_ack               : pair consumed, fetch may advance next cycle
//   split_active           : second half of a split pair is pending
//   cnt_dual/single/stall  : saturating cycle counters
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [6:0]       opA,
  input  logic [4:0]       rdA,
  input  logic [4:0]       rs1A,
  input  logic [4:0]       rs2A,
  input  logic [6:0]       opB,
  input  logic [4:0]       rdB,
  input  logic [4:0]       rs1B,
  input  logic [4:0]       rs2B,
  input  logic             trigger,
  input  logic             clr_cnt,
  output logic             issue_a,
  output logic             issue_b,
  output logic             pair_ack,
  output logic             split_active,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_stall
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_dual_q, cnt_dual_d;
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic supA, supB, raw, waw;
  logic stall_ev;

  // Lane A sources never matter: A always issues no later than B.
  logic unused_lane_a_srcs;
  assign unused_lane_a_srcs = ^{rs1A, rs2A};

  pair_hazard u_hazard (
    .opA  (opA),
    .rdA  (rdA),
    .opB  (opB),
    .rdB  (rdB),
    .rs1B (rs1B),
    .rs2B (rs2B),
    .supA (supA),
    .supB (supB),
    .raw  (raw),
    .waw  (waw)
  );

  // FSM next state and Mealy outputs. Outputs are forced low while rst is
  // high so downstream write enables are quiet during reset.
  always_comb begin
    state_d  = state_q;
    issue_a  = 1'b0;
    issue_b  = 1'b0;
    pair_ack = 1'b0;
    stall_ev = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_PAIR: begin
          if (in_valid) begin
            if (trigger) begin
              stall_ev = 1'b1;
            end else if (raw || waw) begin
              issue_a = 1'b1;
              state_d = S_SPLIT;
            end else begin
              issue_a  = supA;
              issue_b  = supB;
              pair_ack = 1'b1;
            end
          end
        end
        S_SPLIT: begin
          // Pair is held upstream because it was not acked; in_valid is ignored.
          if (trigger) begin
            stall_ev = 1'b1;
          end else begin
            issue_b  = 1'b1;
            pair_ack = 1'b1;
            state_d  = S_PAIR;
          end
        end
        default: state_d = S_PAIR;
      endcase
    end
  end

  assign split_active = !rst && (state_q == S_SPLIT);

  // Saturating counters; clear wins over a same-cycle event.
  always_comb begin
    cnt_dual_d   = cnt_dual_q;
    cnt_single_d = cnt_single_q;
    cnt_stall_d  = cnt_stall_q;
    if (clr_cnt) begin
      cnt_dual_d   = '0;
      cnt_single_d = '0;
      cnt_stall_d  = '0;
    end else begin
      if (issue_a && issue_b && !(&cnt_dual_q))
        cnt_dual_d = cnt_dual_q + CNT_ONE;
      if ((issue_a ^ issue_b) && !(&cnt_single_q))
        cnt_single_d = cnt_single_q + CNT_ONE;
      if (stall_ev && !(&cnt_stall_q))
        cnt_stall_d = cnt_stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PAIR;
      cnt_dual_q   <= '0;
      cnt_single_q <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_dual_q   <= cnt_dual_d;
      cnt_single_q <= cnt_single_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  assign cnt_dual   = cnt_dual_q;
  assign cnt_single = cnt_single_q;
  assign cnt_stall  = cnt_stall_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - self-checking bench for issue_scheduler
module tb_issue_scheduler;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [6:0] opA, opB;
  logic [4:0] rdA, rs1A, rs2A, rdB, rs1B, rs2B;
  logic trigger, clr_cnt;
  logic issue_a, issue_b, pair_ack, split_active;
  logic [CNT_W-1:0] cnt_dual, cnt_single, cnt_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .opA(opA), .rdA(rdA), .rs1A(rs1A), .rs2A(rs2A),
    .opB(opB), .rdB(rdB), .rs1B(rs1B), .rs2B(rs2B),
    .trigger(trigger), .clr_cnt(clr_cnt),
    .issue_a(issue_a), .issue_b(issue_b), .pair_ack(pair_ack),
    .split_active(split_active),
    .cnt_dual(cnt_dual), .cnt_single(cnt_single), .cnt_stall(cnt_stall)
  );

  // Reference model: a "B still owed" flag plus integer counters.
  logic m_pend;
  int   m_dual, m_single, m_stall;
  logic e_a, e_b, e_ack, e_nxt, e_stall;

  function automatic logic sup(input logic [6:0] op);
    return (op == R_OP) || (op == I_OP);
  endfunction

  function automatic logic dependent();
    logic reads_rd;
    reads_rd = (rs1B == rdA) || (opB == R_OP && rs2B == rdA);
    return sup(opA) && sup(opB) && (rdA != 5'd0) && (reads_rd || rdB == rdA);
  endfunction

  always_comb begin
    e_a = 1'b0; e_b = 1'b0; e_ack = 1'b0; e_nxt = m_pend; e_stall = 1'b0;
    if (!rst) begin
      if (m_pend) begin
        if (trigger) e_stall = 1'b1;
        else begin e_b = 1'b1; e_ack = 1'b1; e_nxt = 1'b0; end
      end else if (in_valid) begin
        if (trigger) e_stall = 1'b1;
        else if (dependent()) begin e_a = 1'b1; e_nxt = 1'b1; end
        else begin e_a = sup(opA); e_b = sup(opB); e_ack = 1'b1; end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0; m_dual <= 0; m_single <= 0; m_stall <= 0;
    end else begin
      m_pend <= e_nxt;
      if (clr_cnt) begin
        m_dual <= 0; m_single <= 0; m_stall <= 0;
      end else begin
        if (e_a && e_b)   m_dual   <= (m_dual   < CMAX) ? m_dual + 1   : CMAX;
        if (e_a != e_b)   m_single <= (m_single < CMAX) ? m_single + 1 : CMAX;
        if (e_stall)      m_stall  <= (m_stall  < CMAX) ? m_stall + 1  : CMAX;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model.issue_a", int'(issue_a), int'(e_a));
    chk("model.issue_b", int'(issue_b), int'(e_b));
    chk("model.pair_ack", int'(pair_ack), int'(e_ack));
    chk("model.split_active", int'(split_active), int'(m_pend));
    chk("model.cnt_dual", int'(cnt_dual), m_dual);
    chk("model.cnt_single", int'(cnt_single), m_single);
    chk("model.cnt_stall", int'(cnt_stall), m_stall);
  end

  task automatic drive(input logic v,
                       input logic [6:0] oa, input logic [4:0] da, input logic [4:0] s1a, input logic [4:0] s2a,
                       input logic [6:0] ob, input logic [4:0] db, input logic [4:0] s1b, input logic [4:0] s2b);
    in_valid = v;
    opA = oa; rdA = da; rs1A = s1a; rs2A = s2a;
    opB = ob; rdB = db; rs1B = s1b; rs2B = s2b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic a, input logic b, input logic ack);
    @(negedge clk);
    chk({tag, ".issue_a"}, int'(issue_a), int'(a));
    chk({tag, ".issue_b"}, int'(issue_b), int'(b));
    chk({tag, ".pair_ack"}, int'(pair_ack), int'(ack));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trigger = 1'b0; clr_cnt = 1'b0;
    // addi x1,x0,5 | add x3,x4,x5 presented during reset: must stay quiet
    drive(1, I_OP, 1, 0, 5, R_OP, 3, 4, 5);
    outs("reset", 0, 0, 0);
    chk("reset.split_active", int'(split_active), 0);
    chk("reset.cnt_dual", int'(cnt_dual), 0);
    tick();
    rst = 1'b0;

    // clean pair: dual issue
    outs("clean", 1, 1, 1);
    tick();
    chk("clean.cnt_dual", int'(cnt_dual), 1);

    // RAW: add x5,x1,x2 | addi x6,x5,3
    drive(1, R_OP, 5, 1, 2, I_OP, 6, 5, 3);
    outs("raw.c0", 1, 0, 0);
    tick();
    chk("raw.split_active", int'(split_active), 1);
    outs("raw.c1", 0, 1, 1);
    tick();
    chk("raw.split_done", int'(split_active), 0);
    chk("raw.cnt_single", int'(cnt_single), 2);

    // WAW: addi x7,x1,1 | addi x7,x2,2
    drive(1, I_OP, 7, 1, 1, I_OP, 7, 2, 2);
    outs("waw.c0", 1, 0, 0);
    tick();
    outs("waw.c1", 0, 1, 1);
    tick();
    chk("waw.cnt_single", int'(cnt_single), 4);

    // rdA = x0 never hazards: addi x0,x1,1 | add x8,x0,x0
    drive(1, I_OP, 0, 1, 1, R_OP, 8, 0, 0);
    outs("x0", 1, 1, 1);
    tick();
    chk("x0.split_active", int'(split_active), 0);
    chk("x0.cnt_dual", int'(cnt_dual), 2);

    // RAW through rs2 then stall 3 cycles in split: add x5,x1,x2 | add x9,x5,x5
    drive(1, R_OP, 5, 1, 2, R_OP, 9, 5, 5);
    outs("stall.c0", 1, 0, 0);
    tick();
    trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      outs("stall.hold", 0, 0, 0);
      chk("stall.split_active", int'(split_active), 1);
      tick();
    end
    chk("stall.cnt_stall", int'(cnt_stall), 3);
    trigger = 1'b0;
    outs("stall.release", 0, 1, 1);
    tick();
    in_valid = 1'b0;
    outs("stall.idle", 0, 0, 0);
    tick();
    chk("stall.cnt_single", int'(cnt_single), 6);

    // unsupported A (load) with dependent-looking R-type B
    drive(1, LD_OP, 5, 1, 0, R_OP, 6, 5, 1);
    outs("unsupA", 0, 1, 1);
    tick();
    chk("unsupA.cnt_single", int'(cnt_single), 7);
    drive(1, LD_OP, 5, 1, 0, BR_OP, 5, 5, 1);
    outs("unsup_both", 0, 0, 1);
    tick();
    chk("unsup_both.cnt_single", int'(cnt_single), 7);
    chk("unsup_both.cnt_dual", int'(cnt_dual), 2);

    // stall in S_PAIR counts only with a pair present
    drive(1, I_OP, 1, 0, 5, R_OP, 3, 4, 5);
    trigger = 1'b1;
    outs("pair_stall", 0, 0, 0);
    tick();
    chk("pair_stall.cnt_stall", int'(cnt_stall), 4);
    in_valid = 1'b0;
    tick();
    chk("idle_stall.cnt_stall", int'(cnt_stall), 4);
    trigger = 1'b0;

    // saturation and clear
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr.cnt_stall", int'(cnt_stall), 0);
    chk("clr.cnt_single", int'(cnt_single), 0);
    drive(1, I_OP, 1, 0, 5, R_OP, 3, 4, 5);
    for (int i = 0; i < 15; i++) tick();
    chk("sat.cnt_dual15", int'(cnt_dual), 15);
    tick();
    tick();
    chk("sat.cnt_dual_hold", int'(cnt_dual), 15);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_vs_event.cnt_dual", int'(cnt_dual), 0);

    // reset in the middle of a split
    drive(1, R_OP, 5, 1, 2, I_OP, 6, 5, 3);
    tick();
    chk("rst_split.split_active", int'(split_active), 1);
    chk("rst_split.cnt_single", int'(cnt_single), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_split.split_now", int'(split_active), 0);
    chk("rst_split.cnt_single_now", int'(cnt_single), 0);
    chk("rst_split.issue_b_now", int'(issue_b), 0);
    tick();
    rst = 1'b0;
    outs("rst_split.replay", 1, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
